// File: rtl/prescaled_mod_counter_tick_gen.sv
// Slow-enable generator: one-cycle stick strobe every DIV enabled cycles.
// Latency: stick is combinational from en and the prescale count; the count updates on the next edge.
// Backpressure: none; en low freezes the partial count so no strobe is lost or duplicated.
module tick_gen #(
  parameter int DIV = 2**25,
  parameter int PW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic stick
);

  // Terminal prescale count; with DIV=1 this is zero and every enabled cycle strobes.
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  logic [PW-1:0] ps;

  // The strobe marks the cycle whose closing edge steps the counter.
  assign stick = en && (ps == PS_LAST);

  // Prescale count: restart on clear, advance only while enabled, roll over on the strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps <= '0;
    end else if (clr) begin
      ps <= '0;
    end else if (en) begin
      if (stick) begin
        ps <= '0;
      end else begin
        ps <= ps + 1'b1;
      end
    end
  end

endmodule

// File: rtl/prescaled_mod_counter.sv
// Modulo up/down counter with wrap or one-shot mode, stepped by a prescaled enable strobe.
// Latency: q moves on the edge closing a step cycle; wrap and done are registered one cycle later than the step decision.
// Backpressure: none; en stalls both prescaler and counter, syn_clr and load act regardless of en.
module prescaled_mod_counter #(
  parameter int N       = 4,
  parameter int MAX_VAL = 2**N - 1,
  parameter int DIV     = 2**25,
  parameter int PW      = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         oneshot,
  input  logic [N-1:0] d,
  input  logic         syn_clr,
  input  logic         load,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         stick,
  output logic         wrap,
  output logic         done
);

  // MAX_VAL never exceeds 2**N-1, so the terminal count fits in N bits and the
  // load saturation compare can stay at width N.
  localparam logic [N-1:0] TOP = N'(MAX_VAL);

  logic         ps_clr;
  logic [N-1:0] q_nxt;
  logic         wrap_nxt;
  logic         done_nxt;

  // Any clear or load restarts the prescale period so the first step lands a full DIV cycles later.
  assign ps_clr = syn_clr | load;

  tick_gen #(
    .DIV (DIV),
    .PW  (PW)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (ps_clr),
    .stick (stick)
  );

  assign max_tick = (q == TOP);
  assign min_tick = (q == '0);

  // Next-state: clear beats load beats step beats hold; wrap is a pulse so it defaults low.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    done_nxt = done;
    if (syn_clr) begin
      q_nxt    = '0;
      done_nxt = 1'b0;
    end else if (load) begin
      q_nxt    = (d > TOP) ? TOP : d;
      done_nxt = 1'b0;
    end else if (stick) begin
      if (up) begin
        if (q < TOP) begin
          q_nxt    = q + 1'b1;
          done_nxt = 1'b0;
        end else if (!oneshot) begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
          done_nxt = 1'b0;
        end else begin
          // One-shot at the top: hold and flag completion until something moves q.
          done_nxt = 1'b1;
        end
      end else begin
        if (q > '0) begin
          q_nxt    = q - 1'b1;
          done_nxt = 1'b0;
        end else if (!oneshot) begin
          q_nxt    = TOP;
          wrap_nxt = 1'b1;
          done_nxt = 1'b0;
        end else begin
          done_nxt = 1'b1;
        end
      end
    end
  end

  // Counter state and status flags; reset clears everything without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
      done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_prescaled_mod_counter.sv
module tb_prescaled_mod_counter;

  localparam int NA = 4;
  localparam int MA = 9;
  localparam int DA = 4;
  localparam int NB = 3;
  localparam int MB = 7;
  localparam int DB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=4, MAX_VAL=9, DIV=4
  logic          rst_a, en_a, up_a, os_a, clr_a, ld_a;
  logic [NA-1:0] d_a, q_a;
  logic          max_a, min_a, stick_a, wrap_a, done_a;

  // Instance B: N=3, MAX_VAL=7, DIV=1
  logic          rst_b, en_b, up_b, os_b, clr_b, ld_b;
  logic [NB-1:0] d_b, q_b;
  logic          max_b, min_b, stick_b, wrap_b, done_b;

  prescaled_mod_counter #(.N(NA), .MAX_VAL(MA), .DIV(DA)) dut_a (
    .clk(clk), .reset(rst_a), .en(en_a), .up(up_a), .oneshot(os_a), .d(d_a),
    .syn_clr(clr_a), .load(ld_a), .q(q_a), .max_tick(max_a), .min_tick(min_a),
    .stick(stick_a), .wrap(wrap_a), .done(done_a)
  );

  prescaled_mod_counter #(.N(NB), .MAX_VAL(MB), .DIV(DB)) dut_b (
    .clk(clk), .reset(rst_b), .en(en_b), .up(up_b), .oneshot(os_b), .d(d_b),
    .syn_clr(clr_b), .load(ld_b), .q(q_b), .max_tick(max_b), .min_tick(min_b),
    .stick(stick_b), .wrap(wrap_b), .done(done_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: counter value, prescale count, done flag, wrap pulse
  int mq_a, mps_a, mq_b, mps_b;
  bit mdone_a, mwrap_a, mdone_b, mwrap_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural model of one clock edge, written from the counting rules.
  task automatic model(input int maxv, input int div, input logic rst, input logic en,
                       input logic up, input logic os, input logic clr, input logic ld,
                       input int d, inout int q, inout int ps, inout bit done, inout bit wrap);
    bit step;
    wrap = 1'b0;
    if (!rst) begin
      q = 0; ps = 0; done = 1'b0;
    end else if (clr) begin
      q = 0; ps = 0; done = 1'b0;
    end else if (ld) begin
      q = (d > maxv) ? maxv : d; ps = 0; done = 1'b0;
    end else if (en) begin
      step = (ps == div - 1);
      ps   = (ps + 1) % div;
      if (step) begin
        if (up) begin
          if (q < maxv) begin q = q + 1; done = 1'b0; end
          else if (!os) begin q = 0; wrap = 1'b1; done = 1'b0; end
          else done = 1'b1;
        end else begin
          if (q > 0) begin q = q - 1; done = 1'b0; end
          else if (!os) begin q = maxv; wrap = 1'b1; done = 1'b0; end
          else done = 1'b1;
        end
      end
    end
  endtask

  // One clock: check strobes before the edge, advance the model, check registered outputs after.
  task automatic cyc();
    #1;
    check("stick_a", stick_a, en_a && (mps_a == DA - 1));
    check("stick_b", stick_b, en_b && (mps_b == DB - 1));
    @(posedge clk);
    model(MA, DA, rst_a, en_a, up_a, os_a, clr_a, ld_a, int'(d_a), mq_a, mps_a, mdone_a, mwrap_a);
    model(MB, DB, rst_b, en_b, up_b, os_b, clr_b, ld_b, int'(d_b), mq_b, mps_b, mdone_b, mwrap_b);
    @(negedge clk);
    check("q_a", q_a, mq_a);
    check("wrap_a", wrap_a, mwrap_a);
    check("done_a", done_a, mdone_a);
    check("max_a", max_a, mq_a == MA);
    check("min_a", min_a, mq_a == 0);
    check("q_b", q_b, mq_b);
    check("wrap_b", wrap_b, mwrap_b);
    check("done_b", done_b, mdone_b);
    check("max_b", max_b, mq_b == MB);
    check("min_b", min_b, mq_b == 0);
  endtask

  initial begin
    rst_a = 1'b0; en_a = 1'b0; up_a = 1'b1; os_a = 1'b0; clr_a = 1'b0; ld_a = 1'b0; d_a = '0;
    rst_b = 1'b0; en_b = 1'b0; up_b = 1'b1; os_b = 1'b0; clr_b = 1'b0; ld_b = 1'b0; d_b = '0;
    mq_a = 0; mps_a = 0; mdone_a = 1'b0; mwrap_a = 1'b0;
    mq_b = 0; mps_b = 0; mdone_b = 1'b0; mwrap_b = 1'b0;

    // Reset state
    #2;
    check("rst_q", q_a, 0);
    check("rst_min", min_a, 1);
    check("rst_max", max_a, 0);
    check("rst_stick", stick_a, 0);
    check("rst_wrap", wrap_a, 0);
    check("rst_done", done_a, 0);
    cyc();

    // Count up with wrap
    rst_a = 1'b1; en_a = 1'b1; up_a = 1'b1; os_a = 1'b0;
    repeat (4) cyc();
    check("up_first_step", q_a, 1);
    repeat (32) cyc();
    check("up_q9", q_a, 9);
    check("up_max_tick", max_a, 1);
    repeat (4) cyc();
    check("up_wrap_q", q_a, 0);
    check("up_wrap_pulse", wrap_a, 1);
    cyc();
    check("up_wrap_one_cycle", wrap_a, 0);

    // Count down from zero wraps to MAX_VAL
    up_a = 1'b0;
    repeat (3) cyc();
    check("dn_wrap_q", q_a, 9);
    check("dn_wrap_pulse", wrap_a, 1);
    repeat (4) cyc();
    check("dn_q8", q_a, 8);

    // One-shot up from a load of 8
    os_a = 1'b1; up_a = 1'b1; ld_a = 1'b1; d_a = 4'd8;
    cyc();
    ld_a = 1'b0;
    check("os_load", q_a, 8);
    repeat (4) cyc();
    check("os_q9", q_a, 9);
    check("os_done_low", done_a, 0);
    repeat (4) cyc();
    check("os_hold_q", q_a, 9);
    check("os_done_set", done_a, 1);
    up_a = 1'b0;
    repeat (4) cyc();
    check("os_rev_q", q_a, 8);
    check("os_rev_done", done_a, 0);

    // Saturating load, then clear beating load
    ld_a = 1'b1; d_a = 4'd15;
    cyc();
    ld_a = 1'b0;
    check("load_sat", q_a, 9);
    clr_a = 1'b1; ld_a = 1'b1; d_a = 4'd5;
    cyc();
    clr_a = 1'b0; ld_a = 1'b0;
    check("clr_over_load", q_a, 0);

    // Pause the prescaler with ps=2; the remaining 2 cycles survive the pause
    up_a = 1'b1; os_a = 1'b0;
    repeat (2) cyc();
    en_a = 1'b0;
    repeat (5) cyc();
    check("pause_hold", q_a, 0);
    en_a = 1'b1;
    cyc();
    check("resume_1", q_a, 0);
    cyc();
    check("resume_2", q_a, 1);

    // Random traffic against the model
    repeat (400) begin
      en_a  = ($urandom_range(0, 9) < 8);
      up_a  = 1'($urandom_range(0, 1));
      os_a  = 1'($urandom_range(0, 1));
      clr_a = ($urandom_range(0, 99) < 3);
      ld_a  = ($urandom_range(0, 99) < 5);
      d_a   = 4'($urandom_range(0, 15));
      cyc();
    end
    clr_a = 1'b0; ld_a = 1'b0;

    // DIV=1 instance: steps every enabled cycle
    rst_b = 1'b1; en_b = 1'b1; up_b = 1'b1; os_b = 1'b1;
    repeat (3) cyc();
    check("b_q3", q_b, 3);
    repeat (5) cyc();
    check("b_top", q_b, 7);
    check("b_done", done_b, 1);

    // Asynchronous reset between edges
    #2;
    rst_b = 1'b0;
    #1;
    check("b_async_q", q_b, 0);
    check("b_async_done", done_b, 0);
    mq_b = 0; mps_b = 0; mdone_b = 1'b0; mwrap_b = 1'b0;
    rst_b = 1'b1; os_b = 1'b0;
    repeat (10) cyc();
    check("b_after_reset", q_b, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
